fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode/control logic. It generates word-addressed fetch requests (PC increments by 1), issues them to instruction memory over a request/grant, in-order response interface, and buffers returned instructions with their PCs in a small queue. It then presents them to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
DEPTH, 4, queue entries and maximum fetches outstanding plus queued (power of two, ≥2)
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  word address of the request
imem_gnt  input  1  memory accepts the request this cycle (transfer = imem_req & imem_gnt)
imem_rvalid  input  1  response valid; in order; at least 1 cycle after its grant
imem_rdata  input  32  instruction word for the oldest outstanding request
redirect  input  1  branch/jump taken; flush and restart
redirect_pc  input  32  new fetch address
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts (transfer = out_valid & out_ready)
out_instr  output  32  instruction word
out_pc  output  32  PC of out_instr
out_next_pc  output  32  out_pc + 1 (mod 2^32)
resp_err  output  1  sticky: rvalid arrived with nothing outstanding

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC; queue empty; live=0, drop=0; resp_err=0. While rst=1: imem_req=0, out_valid=0, imem_rvalid ignored. Instruction memory shares rst and cancels its own in-flight reads.
- Counters (width clog2(DEPTH)+1): count = queue occupancy; live = outstanding responses to keep; drop = outstanding responses to discard.
- Issue: imem_req = !rst & !redirect & (count + live + drop < DEPTH); imem_addr = fetch_pc. On transfer: fetch_pc += 1 (wraps 32'hFFFFFFFF→0), live += 1. imem_req may stay high across cycles; the address changes only after a transfer.
- Response: on imem_rvalid, if drop>0 then drop -= 1 and the data is discarded. Else if live>0, {imem_rdata, pc} is pushed, live -= 1. Else resp_err <= 1 and the data is ignored. A response pushed in cycle N is visible on out_* in cycle N+1 (1-cycle latency; no combinational rdata→out_instr path).
- Response PC: a separate response-PC register, set with fetch_pc on redirect/reset and incremented on each accepted (non-dropped) response.
- Output: out_valid = (count>0) & !redirect & !rst; out_* show the queue head. Pop on transfer. Push and pop in the same cycle leave count unchanged. A full queue cannot overflow because of the issue credit rule.
- Redirect (priority over everything except rst), at that edge:
  - fetch_pc and response PC <= redirect_pc.
  - queue cleared (count=0).
  - drop <= drop + live − (imem_rvalid ? 1 : 0), live <= 0. The response arriving in the redirect cycle is discarded.
  - no grant is possible that cycle (imem_req=0); no pop (out_valid=0).
- Back-to-back redirects: each one restarts; drop accumulates correctly.
- New issues are permitted while drop>0. In-order return guarantees old responses drain first.
- Optional FSM view: RUN (drop=0) / DRAIN (drop>0). Both issue and accept; DRAIN discards.

Decomposition:
- Shared package: fetch word width 32, PC increment constant 1, RESET_PC default.
- One sub-module, fetch_queue: synchronous FIFO of {pc, instr} with push, pop, flush, count, and head outputs.
- Counters, credit logic and redirect/drop logic live in fetch_unit.

Test Plan:
- Reset then imem_gnt=1, 1-cycle response, out_ready=1, rdata=addr+32'h100 → out_pc sequence 0,1,2,3…, out_instr 0x100,0x101…, one per cycle after a 2-cycle fill, out_next_pc=out_pc+1.
- Hold out_ready=0 → exactly DEPTH(4) requests granted, then imem_req=0. out_pc stays 0 until ready; releasing ready drains 0..3 in order, then fetching resumes at 4.
- Response latency 3, two outstanding, redirect to 32'h40 → both old responses dropped, out_valid=0 during the flush, first output out_pc=0x40 with its matching rdata.
- Redirect in the same cycle an rvalid arrives and out_valid=1 → no pop, that response dropped, queue empty next cycle, fetch restarts at redirect_pc.
- fetch_pc at 32'hFFFFFFFE, run 3 fetches → addresses FFFFFFFE, FFFFFFFF, 0; out_next_pc for the FFFFFFFF entry = 0.
- Spurious imem_rvalid with live=drop=0 → resp_err=1 and stays 1; queue unchanged. Assert rst mid-stream with a full queue → next cycle out_valid=0, imem_addr=RESET_PC, resp_err=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd1;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } qEntry_t;

  // RUN: no stale responses pending; DRAIN: discarding pre-redirect responses.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect and decode handshake.
// Handshakes: a request transfers when imem_req & imem_gnt, an instruction transfers when out_valid & out_ready.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_next_pc;
  logic              resp_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output out_valid, out_instr, out_pc, out_next_pc, resp_err,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  out_valid, out_instr, out_pc, out_next_pc, resp_err,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs; flush empties it in one cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WORD_W-1:0]        pushPc,
  input  logic [WORD_W-1:0]        pushInstr,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WORD_W-1:0]        headPc,
  output logic [WORD_W-1:0]        headInstr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  qEntry_t        mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{pc: pushPc, instr: pushInstr};
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign headPc    = mem[rdPtr].pc;
  assign headInstr = mem[rdPtr].instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture
// into a small queue, and redirect flush with discard of stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus,
  output fetchState_t  dbgState
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [WORD_W-1:0] fetchPcQ, fetchPcD;
  logic [WORD_W-1:0] respPcQ, respPcD;
  logic [CW-1:0]     liveQ, liveD;
  logic [CW-1:0]     dropQ, dropD;
  logic              respErrQ, respErrD;
  fetchState_t       stateQ, stateD;

  logic [CW-1:0]     count;
  logic [SW-1:0]     inFlight;
  logic              issue, gntFire, respFire;
  logic              dropResp, accept, spurious;
  logic              push, pop, outValid;
  logic [WORD_W-1:0] headPc, headInstr;

  always_comb begin
    inFlight = SW'(count) + SW'(liveQ) + SW'(dropQ);
    issue    = !rst && !bus.redirect && (inFlight < SW'(DEPTH));
    gntFire  = issue && bus.imem_gnt;
    respFire = !rst && bus.imem_rvalid;
    dropResp = respFire && (dropQ != '0);
    accept   = respFire && (dropQ == '0) && (liveQ != '0);
    spurious = respFire && (dropQ == '0) && (liveQ == '0);
    push     = accept && !bus.redirect;
    outValid = (count != '0) && !bus.redirect && !rst;
    pop      = outValid && bus.out_ready;

    fetchPcD = fetchPcQ;
    respPcD  = respPcQ;
    liveD    = liveQ;
    dropD    = dropQ;
    respErrD = respErrQ || spurious;

    if (bus.redirect) begin
      // Everything still outstanding becomes stale; a response landing now is discarded too.
      fetchPcD = bus.redirect_pc;
      respPcD  = bus.redirect_pc;
      liveD    = '0;
      dropD    = dropQ + liveQ - CW'(dropResp || accept);
    end else begin
      if (gntFire) fetchPcD = fetchPcQ + PC_INC;
      if (push)    respPcD  = respPcQ + PC_INC;
      liveD = liveQ + CW'(gntFire) - CW'(accept);
      dropD = dropQ - CW'(dropResp);
    end

    stateD = (dropD != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPcQ <= RESET_PC;
      respPcQ  <= RESET_PC;
      liveQ    <= '0;
      dropQ    <= '0;
      respErrQ <= 1'b0;
      stateQ   <= RUN;
    end else begin
      fetchPcQ <= fetchPcD;
      respPcQ  <= respPcD;
      liveQ    <= liveD;
      dropQ    <= dropD;
      respErrQ <= respErrD;
      stateQ   <= stateD;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .pushPc    (respPcQ),
    .pushInstr (bus.imem_rdata),
    .pop       (pop),
    .count     (count),
    .headPc    (headPc),
    .headInstr (headInstr)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetchPcQ;
  assign bus.out_valid   = outValid;
  assign bus.out_pc      = headPc;
  assign bus.out_instr   = headInstr;
  assign bus.out_next_pc = headPc + PC_INC;
  assign bus.resp_err    = respErrQ;
  assign dbgState        = stateQ;

endmodule
